// File: rtl/fp12_pkg.sv
// FP12 product format and fixed-point constants shared by the dot-product accumulator.
package fp12_pkg;

  localparam int FP12_W    = 12;
  localparam int EXP_W     = 5;
  localparam int MAN_W     = 6;
  localparam int EXP_BIAS  = 14;
  localparam int FRAC_BITS = 20;
  // {1,man} << exp already lands on the 2^-FRAC_BITS grid; this term is zero.
  localparam int FIX_SHIFT = FRAC_BITS - EXP_BIAS - MAN_W;
  localparam int FIX_W     = 40;
  localparam int SUM_W     = 42;

  // Field order fixes the bit positions: sign[11], exp[10:6], man[5:0].
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp12_t;

endpackage

// File: rtl/fp12_to_fixed.sv
// Converts one FP12 product to signed fixed point with 1.0 = 2^FRAC_BITS; exp = 0 is zero.
module fp12_to_fixed
  import fp12_pkg::*;
(
  input  fp12_t                   q,
  output logic signed [FIX_W-1:0] fix
);

  logic [FIX_W-1:0] mag;

  always_comb begin
    mag = {{(FIX_W-MAN_W-1){1'b0}}, 1'b1, q.man} << (int'(q.exp) + FIX_SHIFT);
    fix = '0;
    if (q.exp != '0) begin
      fix = q.sign ? -$signed(mag) : $signed(mag);
    end
  end

endmodule

// File: rtl/fp12_dot_accum.sv
// Four-lane FP12 product reduction: convert, 4-way add, saturating accumulate per reduction.
module fp12_dot_accum
  import fp12_pkg::*;
#(
  parameter int ACC_W = 48,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_last,
  input  logic [FP12_W-1:0] qa,
  input  logic [FP12_W-1:0] qb,
  input  logic [FP12_W-1:0] qc,
  input  logic [FP12_W-1:0] qd,
  output logic              out_valid,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  localparam int EXT_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
  localparam logic signed [EXT_W-1:0] ACC_MAX = {{(EXT_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] ACC_MIN = {{(EXT_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  // Returns {saturated, clamped value}.
  function automatic logic [ACC_W:0] sat_acc(input logic signed [EXT_W-1:0] v);
    if (v > ACC_MAX)      return {1'b1, ACC_MAX[ACC_W-1:0]};
    else if (v < ACC_MIN) return {1'b1, ACC_MIN[ACC_W-1:0]};
    else                  return {1'b0, v[ACC_W-1:0]};
  endfunction

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic [FP12_W-1:0]       q_in [4];
  logic signed [FIX_W-1:0] fix_p0_d [4];
  logic signed [FIX_W-1:0] fix_p0_q [4];
  logic                    vld_p0_d, vld_p0_q, last_p0_d, last_p0_q;
  logic signed [SUM_W-1:0] sum_p1_d, sum_p1_q;
  logic                    vld_p1_d, vld_p1_q, last_p1_d, last_p1_q;
  logic signed [ACC_W-1:0] acc_d, acc_q;
  logic [CNT_W-1:0]        cnt_d, cnt_q;
  logic                    ovf_d, ovf_q;
  logic signed [EXT_W-1:0] acc_ext;
  logic signed [ACC_W-1:0] acc_sat;
  logic                    sat_hit;
  logic [CNT_W-1:0]        cnt_inc;
  logic                    ovf_acc;
  logic                    vld_p2_d, vld_p2_q;
  logic signed [ACC_W-1:0] res_sum_p2_d, res_sum_p2_q;
  logic [CNT_W-1:0]        res_cnt_p2_d, res_cnt_p2_q;
  logic                    res_ovf_p2_d, res_ovf_p2_q;
  logic                    out_valid_d, out_valid_q;
  logic [ACC_W-1:0]        out_sum_d, out_sum_q;
  logic [CNT_W-1:0]        out_count_d, out_count_q;
  logic                    out_ovf_d, out_ovf_q;

  assign q_in[0] = qa;
  assign q_in[1] = qb;
  assign q_in[2] = qc;
  assign q_in[3] = qd;

  // S1: per-lane conversion
  for (genvar i = 0; i < 4; i++) begin : g_cvt
    fp12_to_fixed u_cvt (
      .q   (q_in[i]),
      .fix (fix_p0_d[i])
    );
  end

  always_comb begin
    vld_p0_d  = in_valid;
    last_p0_d = in_valid & in_last;

    // S2: 4-way sum
    vld_p1_d  = vld_p0_q;
    last_p1_d = vld_p0_q & last_p0_q;
    sum_p1_d  = '0;
    for (int i = 0; i < 4; i++) begin
      sum_p1_d = sum_p1_d + {{(SUM_W-FIX_W){fix_p0_q[i][FIX_W-1]}}, fix_p0_q[i]};
    end

    // S3: saturating accumulate; a last beat hands the total off and restarts from zero
    acc_ext = {{(EXT_W-ACC_W){acc_q[ACC_W-1]}}, acc_q}
            + {{(EXT_W-SUM_W){sum_p1_q[SUM_W-1]}}, sum_p1_q};
    {sat_hit, acc_sat} = sat_acc(acc_ext);
    cnt_inc = sat_cnt(cnt_q);
    ovf_acc = ovf_q | sat_hit;

    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (vld_p1_q) begin
      if (last_p1_q) begin
        acc_d = '0;
        cnt_d = '0;
        ovf_d = 1'b0;
      end else begin
        acc_d = acc_sat;
        cnt_d = cnt_inc;
        ovf_d = ovf_acc;
      end
    end
    vld_p2_d     = vld_p1_q & last_p1_q;
    res_sum_p2_d = acc_sat;
    res_cnt_p2_d = cnt_inc;
    res_ovf_p2_d = ovf_acc;

    // Output registers hold between pulses
    out_valid_d = vld_p2_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    if (vld_p2_q) begin
      out_sum_d   = res_sum_p2_q;
      out_count_d = res_cnt_p2_q;
      out_ovf_d   = res_ovf_p2_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p0_q    <= 1'b0;
      last_p0_q   <= 1'b0;
      vld_p1_q    <= 1'b0;
      last_p1_q   <= 1'b0;
      vld_p2_q    <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      vld_p0_q    <= vld_p0_d;
      last_p0_q   <= last_p0_d;
      vld_p1_q    <= vld_p1_d;
      last_p1_q   <= last_p1_d;
      vld_p2_q    <= vld_p2_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  // Datapath registers load only with their valid and are never read without it.
  always_ff @(posedge clk) begin
    if (in_valid) fix_p0_q <= fix_p0_d;
    if (vld_p0_q) sum_p1_q <= sum_p1_d;
    if (vld_p2_d) begin
      res_sum_p2_q <= res_sum_p2_d;
      res_cnt_p2_q <= res_cnt_p2_d;
      res_ovf_p2_q <= res_ovf_p2_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_fp12_dot_accum.sv
// Bench for fp12_dot_accum: two instances (ACC_W 48 and 40) driven together against a reduction model.
module tb_fp12_dot_accum;

  localparam longint CNT_MAX = 65535;

  localparam logic [11:0] P6    = 12'b0_10000_100000;
  localparam logic [11:0] M3    = 12'b1_01111_100000;
  localparam logic [11:0] P2    = 12'b0_01111_000000;
  localparam logic [11:0] M4    = 12'b1_10000_000000;
  localparam logic [11:0] P1    = 12'b0_01110_000000;
  localparam logic [11:0] M2    = 12'b1_01111_000000;
  localparam logic [11:0] M5_25 = 12'b1_10000_010100;
  localparam logic [11:0] P7    = 12'b0_10000_110000;
  localparam logic [11:0] P5_25 = 12'b0_10000_010100;
  localparam logic [11:0] PMAX  = 12'b0_11111_111111;
  localparam logic [11:0] NMAX  = 12'b1_11111_111111;
  localparam logic [11:0] Z1    = 12'b1_00000_111111;
  localparam logic [11:0] Z2    = 12'b0_00000_101010;

  typedef struct {
    longint due;
    longint sum;
    longint cnt;
    bit     ovf;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [11:0] qa = '0, qb = '0, qc = '0, qd = '0;
  logic        ov_a, ov_b, of_a, of_b;
  logic [47:0] os_a;
  logic [39:0] os_b;
  logic [15:0] oc_a, oc_b;

  int     checks = 0;
  int     failures = 0;
  longint cyc = 0;

  longint acc [2];
  longint cnt [2];
  bit     ovf [2];
  res_t   q_a[$], q_b[$], seen_a[$], seen_b[$];
  res_t   h_a, h_b;

  fp12_dot_accum #(.ACC_W(48), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
    .qa(qa), .qb(qb), .qc(qc), .qd(qd),
    .out_valid(ov_a), .out_sum(os_a), .out_count(oc_a), .out_ovf(of_a)
  );

  fp12_dot_accum #(.ACC_W(40), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
    .qa(qa), .qb(qb), .qc(qc), .qd(qd),
    .out_valid(ov_b), .out_sum(os_b), .out_count(oc_b), .out_ovf(of_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // value * 2^20 = (1 + man/64) * 2^(exp-14) * 2^20 = (64 + man) * 2^exp
  function automatic longint fx(logic [11:0] q);
    longint m;
    if (q[10:6] == 5'd0) return 0;
    m = longint'(64 + int'(q[5:0])) * (longint'(1) << q[10:6]);
    return q[11] ? -m : m;
  endfunction

  task automatic model_beat(longint s, bit last, longint due);
    for (int i = 0; i < 2; i++) begin
      longint mx, mn, a;
      res_t   r;
      mx = (longint'(1) << ((i == 0) ? 47 : 39)) - 1;
      mn = -mx - 1;
      a  = acc[i] + s;
      if (a > mx) begin a = mx; ovf[i] = 1'b1; end
      else if (a < mn) begin a = mn; ovf[i] = 1'b1; end
      if (cnt[i] < CNT_MAX) cnt[i] = cnt[i] + 1;
      if (last) begin
        r = '{due: due, sum: a, cnt: cnt[i], ovf: ovf[i]};
        if (i == 0) q_a.push_back(r); else q_b.push_back(r);
        acc[i] = 0; cnt[i] = 0; ovf[i] = 1'b0;
      end else begin
        acc[i] = a;
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      acc[i] = 0; cnt[i] = 0; ovf[i] = 1'b0;
    end
    q_a.delete(); q_b.delete();
    h_a = '{due: 0, sum: 0, cnt: 0, ovf: 1'b0};
    h_b = h_a;
  endtask

  task automatic cmp(string tag, bit ev, res_t e, logic v, longint s, longint c, logic o);
    checks++;
    if (v !== ev || s !== e.sum || c !== e.cnt || o !== e.ovf) begin
      failures++;
      $display("FAIL %s cyc=%0d got v=%0b sum=%0d cnt=%0d ovf=%0b want v=%0b sum=%0d cnt=%0d ovf=%0b",
               tag, cyc, v, s, c, o, ev, e.sum, e.cnt, e.ovf);
    end
  endtask

  task automatic lit(string tag, longint act, longint exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", tag, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      bit   ev;
      res_t e;
      ev = 1'b0; e = h_a;
      if (q_a.size() > 0 && q_a[0].due == cyc) begin e = q_a.pop_front(); ev = 1'b1; h_a = e; end
      cmp("out48", ev, e, ov_a, $signed(os_a), longint'(oc_a), of_a);
      ev = 1'b0; e = h_b;
      if (q_b.size() > 0 && q_b[0].due == cyc) begin e = q_b.pop_front(); ev = 1'b1; h_b = e; end
      cmp("out40", ev, e, ov_b, $signed(os_b), longint'(oc_b), of_b);
      if (ov_a === 1'b1) seen_a.push_back('{due: cyc, sum: $signed(os_a), cnt: longint'(oc_a), ovf: of_a});
      if (ov_b === 1'b1) seen_b.push_back('{due: cyc, sum: $signed(os_b), cnt: longint'(oc_b), ovf: of_b});
    end
  end

  task automatic drive(logic [11:0] a, logic [11:0] b, logic [11:0] c, logic [11:0] d, bit last);
    @(negedge clk);
    in_valid = 1'b1; in_last = last;
    qa = a; qb = b; qc = c; qd = d;
    model_beat(fx(a) + fx(b) + fx(c) + fx(d), last, cyc + 4);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
    end
  endtask

  task automatic check_zero(string tag);
    lit({tag, "_v48"}, longint'(ov_a), 0);
    lit({tag, "_s48"}, longint'(os_a), 0);
    lit({tag, "_c48"}, longint'(oc_a), 0);
    lit({tag, "_o48"}, longint'(of_a), 0);
    lit({tag, "_v40"}, longint'(ov_b), 0);
    lit({tag, "_s40"}, longint'(os_b), 0);
  endtask

  initial begin
    model_reset();
    lit("fx_6", fx(P6), 6 * 1048576);
    lit("fx_m5_25", fx(M5_25), -5505024);
    lit("fx_zero_exp", fx(Z1), 0);
    lit("fx_max", fx(PMAX), 127 * 64'sd2147483648);

    repeat (3) @(negedge clk);
    #1 check_zero("reset");
    @(posedge clk);
    #2 rst = 1'b1;

    // single last beat: 6 - 3 + 2 - 4 = 1.0
    seen_a.delete(); seen_b.delete();
    drive(P6, M3, P2, M4, 1'b1);
    idle(6);
    lit("single_n", seen_a.size(), 1);
    if (seen_a.size() == 1) begin
      lit("single_sum", seen_a[0].sum, 64'h100000);
      lit("single_cnt", seen_a[0].cnt, 1);
      lit("single_ovf", seen_a[0].ovf, 0);
    end

    // exponent-zero inputs contribute nothing
    seen_a.delete(); seen_b.delete();
    drive(Z1, Z2, Z1, 12'h000, 1'b1);
    idle(6);
    lit("zexp_n", seen_a.size(), 1);
    if (seen_a.size() == 1) lit("zexp_sum", seen_a[0].sum, 0);

    // four beats 1, -5.25, 7, 5.25 with a bubble in the middle
    seen_a.delete(); seen_b.delete();
    drive(P6, M3, P2, M4, 1'b0);
    drive(M5_25, Z1, 12'h000, Z2, 1'b0);
    idle(2);
    drive(P7, 12'h000, 12'h000, 12'h000, 1'b0);
    drive(12'h000, P5_25, Z2, 12'h000, 1'b1);
    idle(6);
    lit("four_n", seen_a.size(), 1);
    if (seen_a.size() == 1) begin
      lit("four_sum", seen_a[0].sum, 64'h800000);
      lit("four_cnt", seen_a[0].cnt, 4);
    end

    // back-to-back single-beat reductions
    seen_a.delete(); seen_b.delete();
    drive(P1, 12'h000, 12'h000, 12'h000, 1'b1);
    drive(M2, 12'h000, 12'h000, 12'h000, 1'b1);
    idle(6);
    lit("b2b_n", seen_a.size(), 2);
    if (seen_a.size() == 2) begin
      lit("b2b_sum0", seen_a[0].sum, 64'h100000);
      lit("b2b_sum1", seen_a[1].sum, -64'sh200000);
      lit("b2b_adjacent", seen_a[1].due - seen_a[0].due, 1);
    end

    // saturation on the 40-bit instance, then a clean reduction
    seen_a.delete(); seen_b.delete();
    drive(PMAX, PMAX, PMAX, PMAX, 1'b1);
    drive(P1, 12'h000, 12'h000, 12'h000, 1'b1);
    drive(NMAX, NMAX, NMAX, NMAX, 1'b1);
    idle(6);
    lit("sat_n", seen_b.size(), 3);
    if (seen_b.size() == 3) begin
      lit("sat_pos_sum", seen_b[0].sum, (64'sd1 <<< 39) - 1);
      lit("sat_pos_ovf", seen_b[0].ovf, 1);
      lit("sat_next_sum", seen_b[1].sum, 64'h100000);
      lit("sat_next_ovf", seen_b[1].ovf, 0);
      lit("sat_neg_sum", seen_b[2].sum, -(64'sd1 <<< 39));
      lit("sat_neg_ovf", seen_b[2].ovf, 1);
    end
    if (seen_a.size() == 3) lit("nosat48_ovf", seen_a[0].ovf, 0);

    // reset in the middle of a reduction
    seen_a.delete(); seen_b.delete();
    drive(P1, 12'h000, 12'h000, 12'h000, 1'b0);
    drive(P1, 12'h000, 12'h000, 12'h000, 1'b0);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    #2 rst = 1'b0;
    model_reset();
    #1 check_zero("rst_mid");
    @(posedge clk);
    #2 rst = 1'b1;
    drive(P2, 12'h000, 12'h000, 12'h000, 1'b1);
    idle(6);
    lit("rst_mid_n", seen_a.size(), 1);
    if (seen_a.size() == 1) begin
      lit("rst_mid_sum", seen_a[0].sum, 64'h200000);
      lit("rst_mid_cnt", seen_a[0].cnt, 1);
    end

    // beat counter saturates rather than wrapping
    seen_a.delete(); seen_b.delete();
    for (int i = 0; i < 65537; i++) drive(12'h000, 12'h000, 12'h000, 12'h000, 1'b0);
    drive(P1, 12'h000, 12'h000, 12'h000, 1'b1);
    idle(6);
    lit("cnt_sat_n", seen_a.size(), 1);
    if (seen_a.size() == 1) begin
      lit("cnt_sat_cnt", seen_a[0].cnt, 65535);
      lit("cnt_sat_sum", seen_a[0].sum, 64'h100000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
